// File: rtl/fdc_pkg.sv
// fdc_pkg: shared types and helpers for the floppy transfer engine.
package fdc_pkg;

  // Execution-phase states of the transfer engine
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DSK_RD = 3'd1,
    CPU_RD = 3'd2,
    CPU_WR = 3'd3,
    DSK_WR = 3'd4,
    NEXT   = 3'd5,
    FIN    = 3'd6
  } fdc_state_e;

  // Bit positions inside the sticky status vector
  localparam int ST_OVERRUN_BIT = 0;
  localparam int ST_NODATA_BIT  = 1;
  localparam int ST_EOC_BIT     = 2;

  // Sector length in bytes for an N code (128 << N)
  function automatic int sect_bytes(input logic [2:0] size_n);
    return 128 << size_n;
  endfunction

endpackage

// File: rtl/fdc_sect_buf.sv
// fdc_sect_buf: one-sector single-port RAM, synchronous write, registered read.
// Contents survive reset; only the addressing engine is reset.
module fdc_sect_buf #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Read-first port: rdata returns the old word when writing the same address
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/fdc_xfer_engine.sv
// fdc_xfer_engine: floppy controller execution-phase engine. Moves sectors
// between the disk side and the CPU data register through a one-sector buffer,
// walking sectors up to EOT or terminal count.
// Build macro FDC_OVERRUN_EN adds the CPU service timeout (overrun) timer.
module fdc_xfer_engine
  import fdc_pkg::*;
#(
  parameter  int NUM_DRIVES     = 2,
  parameter  int MAX_SECT_BYTES = 1024,
  parameter  int OVR_TIMEOUT    = 2048,
  localparam int DW             = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          dir,
  input  logic [DW-1:0] drive,
  input  logic [6:0]    cyl,
  input  logic          head,
  input  logic [7:0]    sect_r,
  input  logic [2:0]    size_n,
  input  logic [7:0]    eot,
  input  logic          tc,
  input  logic          cpu_rd_stb,
  input  logic          cpu_wr_stb,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          rqm,
  output logic          dio,
  output logic          busy,
  output logic          dsk_req,
  output logic          dsk_write,
  output logic [DW-1:0] dsk_drive,
  output logic [6:0]    dsk_cyl,
  output logic          dsk_head,
  output logic [7:0]    dsk_sect,
  input  logic          dsk_ack,
  input  logic          dsk_err,
  input  logic [7:0]    dsk_din,
  input  logic          dsk_din_vld,
  output logic [7:0]    dsk_dout,
  input  logic          dsk_dout_rd,
  output logic          done,
  output logic          st_overrun,
  output logic          st_nodata,
  output logic          st_eoc,
  output logic [7:0]    res_sect
);

  localparam int IW = $clog2(MAX_SECT_BYTES);

  fdc_state_e    state, state_nx;
  logic [IW-1:0] idx, idx_nx, last_idx;
  logic [7:0]    sect, eot_q;
  logic          dir_q, head_q;
  logic [DW-1:0] drive_q;
  logic [6:0]    cyl_q;
  logic [2:0]    st_q;
  // gap: one dead cycle while the registered RAM read catches up
  // (after each CPU read strobe, and when priming the disk write stream)
  logic          gap;
  // pad: terminal count seen mid-write, zero-filling the rest of the sector
  logic          pad;
  logic          tc_seen;

  logic          rd_acc, wr_acc, wr_put, at_last, oversize, ovr, eoc_hit;
  logic          buf_we;
  logic [IW-1:0] buf_addr;
  logic [7:0]    buf_wdata, buf_rdata;

  assign rd_acc   = (state == CPU_RD) && !gap && cpu_rd_stb;
  assign wr_acc   = (state == CPU_WR) && !pad && cpu_wr_stb;
  assign wr_put   = wr_acc || ((state == CPU_WR) && pad);
  assign at_last  = (idx == last_idx);
  assign oversize = sect_bytes(size_n) > MAX_SECT_BYTES;
  assign eoc_hit  = (state == NEXT) && (sect == eot_q) && !tc_seen && !tc;

`ifdef FDC_OVERRUN_EN
  localparam int TW = $clog2(OVR_TIMEOUT + 1);
  logic [TW-1:0] timer;

  // A byte left waiting for OVR_TIMEOUT cycles aborts the transfer
  assign ovr = rqm && (timer == TW'(OVR_TIMEOUT - 1)) && !(rd_acc || wr_acc);

  // Service timer: runs while the CPU is being asked, restarts on each strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          timer <= '0;
    else if (!rqm || rd_acc || wr_acc)   timer <= '0;
    else                                 timer <= timer + 1'b1;
  end
`else
  assign ovr = 1'b0;
`endif

  // Buffer port sharing: writers use the current index, streaming readers
  // look one step ahead so the registered read lines up with the output
  always_comb begin
    buf_addr  = idx;
    buf_we    = 1'b0;
    buf_wdata = cpu_din;
    case (state)
      DSK_RD: begin
        buf_we    = dsk_din_vld;
        buf_wdata = dsk_din;
      end
      CPU_WR: begin
        buf_we    = wr_put;
        buf_wdata = pad ? 8'h00 : cpu_din;
      end
      CPU_RD, DSK_WR: buf_addr = idx_nx;
      default: ;
    endcase
  end

  fdc_sect_buf #(.DEPTH(MAX_SECT_BYTES)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .addr  (buf_addr),
    .wdata (buf_wdata),
    .rdata (buf_rdata)
  );

  // Byte index: saturates at the last byte, rewinds between phases
  always_comb begin
    idx_nx = idx;
    case (state)
      DSK_RD: if (dsk_ack) idx_nx = '0;
              else if (dsk_din_vld && !at_last) idx_nx = idx + 1'b1;
      CPU_RD: if (rd_acc && !at_last) idx_nx = idx + 1'b1;
      CPU_WR: if (wr_put) idx_nx = at_last ? '0 : idx + 1'b1;
      DSK_WR: if (!gap && dsk_dout_rd && !at_last) idx_nx = idx + 1'b1;
      default: idx_nx = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next-state: strobes are honoured before tc, overrun beats both
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = oversize ? FIN : (dir ? DSK_RD : CPU_WR);
      DSK_RD: if (dsk_ack) state_nx = dsk_err ? FIN : CPU_RD;
      CPU_RD: if (ovr || tc) state_nx = FIN;
              else if (rd_acc && at_last) state_nx = NEXT;
      CPU_WR: if (ovr) state_nx = FIN;
              else if (wr_put && at_last) state_nx = DSK_WR;
      DSK_WR: if (dsk_ack && !gap) state_nx = dsk_err ? FIN : NEXT;
      NEXT:   state_nx = (tc_seen || tc || sect == eot_q) ? FIN
                       : (dir_q ? DSK_RD : CPU_WR);
      FIN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state != IDLE);
    rqm       = ((state == CPU_RD) && !gap) || ((state == CPU_WR) && !pad);
    dio       = (state == CPU_RD);
    dsk_req   = (state == DSK_RD) || ((state == DSK_WR) && !gap);
    dsk_write = (state == DSK_WR);
    done      = (state == FIN);
    cpu_dout  = (state == CPU_RD) ? buf_rdata : 8'h00;
    dsk_dout  = ((state == DSK_WR) && !gap) ? buf_rdata : 8'h00;
  end

  // Command latch, sector walk, sticky status and result sector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      last_idx <= '0;
      sect     <= '0;
      eot_q    <= '0;
      dir_q    <= 1'b0;
      drive_q  <= '0;
      cyl_q    <= '0;
      head_q   <= 1'b0;
      gap      <= 1'b0;
      pad      <= 1'b0;
      tc_seen  <= 1'b0;
      st_q     <= '0;
      res_sect <= '0;
    end else begin
      idx <= idx_nx;
      gap <= ((state_nx == CPU_RD) && ((state != CPU_RD) || rd_acc)) ||
             ((state_nx == DSK_WR) && (state != DSK_WR));
      pad <= (state_nx == CPU_WR) && (pad || ((state == CPU_WR) && tc));

      if (state == IDLE) tc_seen <= 1'b0;
      else if (tc)       tc_seen <= 1'b1;

      if (state == IDLE && start) begin
        sect     <= sect_r;
        eot_q    <= eot;
        dir_q    <= dir;
        drive_q  <= drive;
        cyl_q    <= cyl;
        head_q   <= head;
        last_idx <= IW'(sect_bytes(size_n) - 1);
        st_q     <= '0;
        if (oversize) begin
          st_q[ST_NODATA_BIT] <= 1'b1;
          res_sect            <= sect_r;
        end
      end

      if (state == NEXT && state_nx != FIN) sect <= sect + 8'd1;

      if (((state == DSK_RD) || (state == DSK_WR && !gap)) && dsk_ack && dsk_err)
        st_q[ST_NODATA_BIT] <= 1'b1;
      if (ovr)     st_q[ST_OVERRUN_BIT] <= 1'b1;
      if (eoc_hit) st_q[ST_EOC_BIT]     <= 1'b1;

      if (state_nx == FIN && state != IDLE && state != FIN) res_sect <= sect;
    end
  end

  assign dsk_drive  = drive_q;
  assign dsk_cyl    = cyl_q;
  assign dsk_head   = head_q;
  assign dsk_sect   = sect;
  assign st_overrun = st_q[ST_OVERRUN_BIT];
  assign st_nodata  = st_q[ST_NODATA_BIT];
  assign st_eoc     = st_q[ST_EOC_BIT];

endmodule

// File: tb/tb_fdc_xfer_engine.sv
// tb_fdc_xfer_engine: table-driven transfers plus hand-written corner cases
// (oversize sector, start ignored while busy, reset mid-write, overrun).
module tb_fdc_xfer_engine;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start = 0, dir = 0, head = 0, tc = 0;
  logic [0:0] drive = '0;
  logic [6:0] cyl = 7'd3;
  logic [7:0] sect_r = 0, eot = 0, cpu_din = 0, dsk_din = 0;
  logic [2:0] size_n = 0;
  logic       cpu_rd_stb = 0, cpu_wr_stb = 0;
  logic       dsk_ack = 0, dsk_err = 0, dsk_din_vld = 0, dsk_dout_rd = 0;
  logic [7:0] cpu_dout, dsk_dout, dsk_sect, res_sect;
  logic       rqm, dio, busy, dsk_req, dsk_write, dsk_head, done;
  logic       st_overrun, st_nodata, st_eoc;
  logic [0:0] dsk_drive;
  logic [6:0] dsk_cyl;

  always #5 clk = ~clk;

  fdc_xfer_engine #(.NUM_DRIVES(2), .MAX_SECT_BYTES(1024), .OVR_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .drive(drive), .cyl(cyl),
    .head(head), .sect_r(sect_r), .size_n(size_n), .eot(eot), .tc(tc),
    .cpu_rd_stb(cpu_rd_stb), .cpu_wr_stb(cpu_wr_stb), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .rqm(rqm), .dio(dio), .busy(busy), .dsk_req(dsk_req),
    .dsk_write(dsk_write), .dsk_drive(dsk_drive), .dsk_cyl(dsk_cyl),
    .dsk_head(dsk_head), .dsk_sect(dsk_sect), .dsk_ack(dsk_ack), .dsk_err(dsk_err),
    .dsk_din(dsk_din), .dsk_din_vld(dsk_din_vld), .dsk_dout(dsk_dout),
    .dsk_dout_rd(dsk_dout_rd), .done(done), .st_overrun(st_overrun),
    .st_nodata(st_nodata), .st_eoc(st_eoc), .res_sect(res_sect)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Event monitor: dsk_req rising edges, done pulses, rqm cycles
  int   req_rise = 0, done_seen = 0, rqm_seen = 0;
  logic req_q = 1'b0;
  always @(negedge clk) begin
    if (dsk_req === 1'b1 && !req_q) req_rise++;
    req_q = (dsk_req === 1'b1);
    if (done === 1'b1) done_seen++;
    if (rqm === 1'b1) rqm_seen++;
  end

  function automatic logic [7:0] rpat(input logic [7:0] s, input int i);
    return s * 8'd29 + 8'(i) * 8'd13 + 8'(i >> 8);
  endfunction

  function automatic logic [7:0] wpat(input logic [7:0] s, input int i);
    return s ^ 8'(i * 7 + 3);
  endfunction

  task automatic wait_req(input int lim, output bit ok);
    ok = 0;
    for (int k = 0; k < lim; k++) begin
      if (dsk_req === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_rqm(input int lim, output bit ok);
    ok = 0;
    for (int k = 0; k < lim; k++) begin
      if (rqm === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int lim, output bit ok, output int waited);
    ok = 0; waited = 0;
    for (int k = 0; k < lim; k++) begin
      if (done === 1'b1) begin ok = 1; break; end
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic pulse_start(input logic d, input logic [2:0] sz,
                             input logic [7:0] s, input logic [7:0] e);
    dir = d; size_n = sz; sect_r = s; eot = e; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  typedef struct {
    logic       dir;
    logic [2:0] size_n;
    logic [7:0] sect_r, eot;
    logic       tc_en;
    logic [7:0] tc_sect;
    int         tc_byte;
    logic       err;
    logic [7:0] x_res;
    logic       x_eoc, x_nodata;
    int         x_req;
  } vec_t;

  vec_t v[7];

  // One full command: plays the disk and the CPU, then checks completion
  task automatic run_vec(input int k, input vec_t t);
    int n, wn, r0, d0, q0, errs, waited;
    logic [7:0] s, exp;
    bit stop, ok, tcd;
    n = 128 << t.size_n;
    r0 = req_rise; d0 = done_seen; q0 = rqm_seen;
    errs = 0; s = t.sect_r; stop = 0;
    pulse_start(t.dir, t.size_n, t.sect_r, t.eot);
    while (!stop) begin
      if (t.dir) begin
        wait_req(20, ok);
        if (!ok) begin errs++; break; end
        if (dsk_write !== 1'b0 || dsk_sect !== s) errs++;
        if (t.err) begin
          dsk_ack = 1; dsk_err = 1; @(negedge clk); dsk_ack = 0; dsk_err = 0;
          break;
        end
        for (int i = 0; i < n; i++) begin
          dsk_din = rpat(s, i); dsk_din_vld = 1; @(negedge clk);
        end
        dsk_din_vld = 0; dsk_ack = 1; @(negedge clk); dsk_ack = 0;
        for (int i = 0; i < n; i++) begin
          wait_rqm(5, ok);
          if (!ok) begin errs++; stop = 1; break; end
          if (dio !== 1'b1 || cpu_dout !== rpat(s, i)) errs++;
          cpu_rd_stb = 1;
          tc = t.tc_en && s == t.tc_sect && i == t.tc_byte - 1;
          @(negedge clk);
          cpu_rd_stb = 0;
          if (tc) begin tc = 0; stop = 1; break; end
          if (rqm !== 1'b0) errs++;
        end
        if (stop) break;
      end else begin
        wn = n; tcd = 0;
        for (int i = 0; i < n; i++) begin
          wait_rqm(5, ok);
          if (!ok) begin errs++; stop = 1; break; end
          if (dio !== 1'b0) errs++;
          cpu_din = wpat(s, i); cpu_wr_stb = 1;
          tc = t.tc_en && s == t.tc_sect && i == t.tc_byte - 1;
          @(negedge clk);
          cpu_wr_stb = 0;
          if (tc) begin tc = 0; tcd = 1; wn = i + 1; break; end
        end
        if (stop) break;
        wait_req(n + 20, ok);
        if (!ok) begin errs++; break; end
        if (dsk_write !== 1'b1 || dsk_sect !== s) errs++;
        for (int i = 0; i < n; i++) begin
          exp = (i < wn) ? wpat(s, i) : 8'h00;
          if (dsk_dout !== exp) errs++;
          dsk_dout_rd = 1; @(negedge clk);
        end
        dsk_dout_rd = 0; dsk_ack = 1; dsk_err = t.err; @(negedge clk);
        dsk_ack = 0; dsk_err = 0;
        if (t.err || tcd) break;
      end
      if (s == t.eot) break;
      s = s + 8'd1;
    end
    wait_done(t.err ? 2 : 20, ok, waited);
    chk($sformatf("v%0d_done", k), ok, 1);
    @(negedge clk);
    chk($sformatf("v%0d_data", k), errs, 0);
    chk($sformatf("v%0d_done_cnt", k), done_seen - d0, 1);
    chk($sformatf("v%0d_res_sect", k), res_sect, t.x_res);
    chk($sformatf("v%0d_st_eoc", k), st_eoc, t.x_eoc);
    chk($sformatf("v%0d_st_nodata", k), st_nodata, t.x_nodata);
    chk($sformatf("v%0d_st_overrun", k), st_overrun, 0);
    chk($sformatf("v%0d_req_cnt", k), req_rise - r0, t.x_req);
    chk($sformatf("v%0d_idle", k), busy, 0);
    if (t.err && t.dir) chk($sformatf("v%0d_no_rqm", k), rqm_seen - q0, 0);
  endtask

  initial begin
    bit ok;
    int waited, r0;

    //      dir  sz    sect    eot    tc  tcsect tcb err  res    eoc nd  req
    v[0] = '{1'b1, 3'd2, 8'hC1, 8'hC1, 1'b0, 8'h00,   0, 1'b0, 8'hC1, 1'b1, 1'b0, 1};
    v[1] = '{1'b1, 3'd0, 8'hC1, 8'hC3, 1'b1, 8'hC2, 100, 1'b0, 8'hC2, 1'b0, 1'b0, 2};
    v[2] = '{1'b0, 3'd1, 8'h05, 8'h05, 1'b1, 8'h05,  10, 1'b0, 8'h05, 1'b0, 1'b0, 1};
    v[3] = '{1'b1, 3'd0, 8'h10, 8'h12, 1'b0, 8'h00,   0, 1'b1, 8'h10, 1'b0, 1'b1, 1};
    v[4] = '{1'b0, 3'd0, 8'hFE, 8'h01, 1'b0, 8'h00,   0, 1'b0, 8'h01, 1'b1, 1'b0, 4};
    v[5] = '{1'b1, 3'd0, 8'h20, 8'h21, 1'b0, 8'h00,   0, 1'b0, 8'h21, 1'b1, 1'b0, 2};
    v[6] = '{1'b0, 3'd0, 8'h30, 8'h31, 1'b0, 8'h00,   0, 1'b1, 8'h30, 1'b0, 1'b1, 1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", ({rqm, dio, busy, dsk_req, dsk_write, done, st_overrun,
                           st_nodata, st_eoc, res_sect, cpu_dout, dsk_dout} === 33'd0), 1);
    rst_n = 1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      run_vec(k, v[k]);
      @(negedge clk);
    end

    // Oversize sector (2048 > 1024): straight to FIN with nodata
    r0 = req_rise;
    pulse_start(1'b1, 3'd4, 8'h44, 8'h44);
    wait_done(3, ok, waited);
    chk("oversize_done", ok, 1);
    @(negedge clk);
    chk("oversize_nodata", st_nodata, 1);
    chk("oversize_res", res_sect, 8'h44);
    chk("oversize_no_req", req_rise - r0, 0);
    @(negedge clk);

    // start and CPU strobes while busy in DSK_RD are ignored
    pulse_start(1'b1, 3'd0, 8'h40, 8'h40);
    wait_req(20, ok);
    chk("busy_req", ok, 1);
    dir = 0; start = 1; cpu_rd_stb = 1; cpu_wr_stb = 1;
    @(negedge clk);
    start = 0; cpu_rd_stb = 0; cpu_wr_stb = 0;
    chk("busy_start_ignored", {dsk_req, dsk_write, rqm, dsk_sect}, {3'b100, 8'h40});

    // Reset mid-transfer in DSK_WR, then a fresh command
    rst_n = 0; @(negedge clk); rst_n = 1; @(negedge clk);
    pulse_start(1'b0, 3'd0, 8'h50, 8'h50);
    for (int i = 0; i < 128; i++) begin
      wait_rqm(5, ok);
      cpu_din = wpat(8'h50, i); cpu_wr_stb = 1; @(negedge clk); cpu_wr_stb = 0;
    end
    wait_req(20, ok);
    chk("dskwr_reached", dsk_write, 1);
    dsk_dout_rd = 1; repeat (3) @(negedge clk); dsk_dout_rd = 0;
    rst_n = 0;
    #1;
    chk("midxfer_reset_outputs", ({rqm, dio, busy, dsk_req, dsk_write, done, st_overrun,
                                   st_nodata, st_eoc, res_sect, cpu_dout, dsk_dout} === 33'd0), 1);
    @(negedge clk); rst_n = 1; @(negedge clk);
    run_vec(7, v[5]);
    @(negedge clk);

`ifdef FDC_OVERRUN_EN
    // CPU never services the read: overrun after 16 waiting cycles
    pulse_start(1'b1, 3'd0, 8'h60, 8'h60);
    wait_req(20, ok);
    for (int i = 0; i < 128; i++) begin
      dsk_din = rpat(8'h60, i); dsk_din_vld = 1; @(negedge clk);
    end
    dsk_din_vld = 0; dsk_ack = 1; @(negedge clk); dsk_ack = 0;
    wait_rqm(5, ok);
    wait_done(40, ok, waited);
    chk("ovr_done", ok, 1);
    chk("ovr_latency", (waited >= 15 && waited <= 17), 1);
    @(negedge clk);
    chk("ovr_status", st_overrun, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
